// File: rtl/pipe_pkg.sv
// Shared defaults and width helpers for the Pipelining result capture block.
package pipe_pkg;
    localparam int N_DEFAULT       = 10;
    localparam int LATENCY_DEFAULT = 3;
    localparam int DEPTH_DEFAULT   = 4;

    // Width needed to hold values 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // count + inflight can reach depth + latency; this width never wraps.
    function automatic int sum_w(input int depth, input int latency);
        return $clog2(depth + latency + 1);
    endfunction

    localparam int SUM_W = sum_w(DEPTH_DEFAULT, LATENCY_DEFAULT);
endpackage

// File: rtl/pipe_valid_delay.sv
// Valid-bit shadow of the Pipelining stage: q rises LATENCY edges after d, inflight counts set bits.
module pipe_valid_delay
    import pipe_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          d,
    output logic                          q,
    output logic [cnt_w(LATENCY)-1:0]     inflight
);
    localparam int IW = cnt_w(LATENCY);

    logic [LATENCY-1:0] vpipe;

    generate
        if (LATENCY == 1) begin : g_one
            always_ff @(posedge clk or posedge rst) begin
                if (rst) vpipe <= '0;
                else     vpipe <= d;
            end
        end else begin : g_shift
            always_ff @(posedge clk or posedge rst) begin
                if (rst) vpipe <= '0;
                else     vpipe <= {vpipe[LATENCY-2:0], d};
            end
        end
    endgenerate

    assign q = vpipe[LATENCY-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + IW'(vpipe[i]);
        end
    end
endmodule

// File: rtl/pipe_result_fifo.sv
// Captures aligned Pipelining results into a show-ahead FIFO; push LATENCY+1 edges after issue.
// Credit: issue_ready drops once stored plus in-flight results would fill the FIFO; overflow is sticky.
module pipe_result_fifo
    import pipe_pkg::*;
#(
    parameter int N       = N_DEFAULT,
    parameter int LATENCY = LATENCY_DEFAULT,
    parameter int DEPTH   = DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       issue_ready,
    input  logic [N-1:0]               f_in,
    output logic [N-1:0]               out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [cnt_w(DEPTH)-1:0]    count,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam int IW = cnt_w(LATENCY);
    localparam int SW = sum_w(DEPTH, LATENCY);

    logic [N-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [IW-1:0] inflight;
    logic          push;
    logic          pop;
    logic          full;
    logic          wr_en;

    pipe_valid_delay #(
        .LATENCY (LATENCY)
    ) u_vdelay (
        .clk      (clk),
        .rst      (rst),
        .d        (in_valid),
        .q        (push),
        .inflight (inflight)
    );

    assign full      = (count == CW'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    // When full, a simultaneous pop frees the slot wr_ptr points at.
    assign wr_en     = push && (!full || pop);
    assign out_data  = mem[rd_ptr];

    assign issue_ready = (SW'(count) + SW'(inflight)) < SW'(DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            if (wr_en && !pop)      count <= count + CW'(1);
            else if (!wr_en && pop) count <= count - CW'(1);
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= f_in;
    end
endmodule

// File: tb/tb_pipe_result_fifo.sv
// Directed bench for pipe_result_fifo with LATENCY=3, DEPTH=4, N=10.
module tb_pipe_result_fifo;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       issue_ready;
    logic [9:0] f_in;
    logic [9:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] count;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    logic [9:0] vals [5];
    logic [9:0] expq [5];

    pipe_result_fifo #(.N(10), .LATENCY(3), .DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .issue_ready (issue_ready),
        .f_in        (f_in),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [9:0] f, input logic r);
        in_valid  = v;
        f_in      = f;
        out_ready = r;
        #1;
    endtask

    // Issue nis operands on consecutive edges; vals[k] is driven in the aligned cycle of issue k.
    task automatic feed(input int nis, input int ncyc, input int pop_cyc, input logic [7:0] ir_mask);
        for (int c = 0; c < ncyc; c++) begin
            logic [9:0] f;
            f = 10'h2AA ^ 10'(c);
            if (c >= 3 && c - 3 < nis) f = vals[c-3];
            drive(c < nis, f, c == pop_cyc);
            check($sformatf("feed_ir_c%0d", c), 32'(issue_ready), 32'(ir_mask[c]));
            tick();
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 10'h155 ^ 10'(i), 1'b1);
            check($sformatf("drain_vld%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("drain_dat%0d", i), 32'(out_data), 32'(expq[i]));
            tick();
        end
        drive(1'b0, 10'h0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 10'h0, 1'b0);
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_issue_ready", 32'(issue_ready), 32'd1);
        rst = 1'b0;

        // Single result: issue, aligned f_in 0x05A, then pop.
        drive(1'b1, 10'h0, 1'b0);
        check("t1_ir", 32'(issue_ready), 32'd1);
        tick();
        drive(1'b0, 10'h0, 1'b0);
        tick();
        drive(1'b0, 10'h0, 1'b0);
        tick();
        drive(1'b0, 10'h05A, 1'b0);
        check("t1_not_yet", 32'(out_valid), 32'd0);
        tick();
        drive(1'b0, 10'h3FF, 1'b1);
        check("t1_vld", 32'(out_valid), 32'd1);
        check("t1_dat", 32'(out_data), 32'h05A);
        check("t1_cnt", 32'(count), 32'd1);
        tick();
        drive(1'b0, 10'h155, 1'b1);
        check("t1_cnt_after", 32'(count), 32'd0);
        check("t1_vld_after", 32'(out_valid), 32'd0);
        tick();
        drive(1'b0, 10'h0, 1'b0);
        check("t1_empty_pop_ignored", 32'(count), 32'd0);

        // Four back-to-back issues fill the FIFO, credit drops while they are in flight.
        vals[0] = 10'd10; vals[1] = 10'd20; vals[2] = 10'd30; vals[3] = 10'd40;
        feed(4, 7, -1, 8'h0F);
        drive(1'b0, 10'h0, 1'b0);
        check("t2_cnt", 32'(count), 32'd4);
        check("t2_ovf", 32'(overflow), 32'd0);
        check("t2_ir", 32'(issue_ready), 32'd0);
        tick();
        check("t2_hold_dat", 32'(out_data), 32'd10);
        expq[0] = 10'd10; expq[1] = 10'd20; expq[2] = 10'd30; expq[3] = 10'd40;
        drain(4);
        check("t2_drained", 32'(count), 32'd0);

        // Full with a simultaneous pop and aligned push of 55.
        vals[0] = 10'd1; vals[1] = 10'd2; vals[2] = 10'd3; vals[3] = 10'd4; vals[4] = 10'd55;
        feed(5, 8, 7, 8'h0F);
        drive(1'b0, 10'h0, 1'b0);
        check("t3_cnt", 32'(count), 32'd4);
        check("t3_ovf", 32'(overflow), 32'd0);
        check("t3_head", 32'(out_data), 32'd2);
        expq[0] = 10'd2; expq[1] = 10'd3; expq[2] = 10'd4; expq[3] = 10'd55;
        drain(4);
        check("t3_drained", 32'(count), 32'd0);

        // Fifth issue ignoring credit while full: dropped, overflow sticks.
        vals[0] = 10'd11; vals[1] = 10'd12; vals[2] = 10'd13; vals[3] = 10'd14; vals[4] = 10'd99;
        feed(5, 8, -1, 8'h0F);
        drive(1'b0, 10'h0, 1'b0);
        check("t4_cnt", 32'(count), 32'd4);
        check("t4_ovf", 32'(overflow), 32'd1);
        check("t4_head", 32'(out_data), 32'd11);
        expq[0] = 10'd11; expq[1] = 10'd12; expq[2] = 10'd13; expq[3] = 10'd14;
        drain(4);
        check("t4_cnt_after", 32'(count), 32'd0);
        check("t4_vld_after", 32'(out_valid), 32'd0);
        check("t4_ovf_sticky", 32'(overflow), 32'd1);

        // Two stored, one in flight, then asynchronous reset mid-cycle.
        vals[0] = 10'd21; vals[1] = 10'd22; vals[2] = 10'd23;
        feed(3, 5, -1, 8'h1F);
        drive(1'b0, 10'd23, 1'b0);
        check("t5_pre_cnt", 32'(count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_cnt", 32'(count), 32'd0);
        check("t5_rst_vld", 32'(out_valid), 32'd0);
        check("t5_rst_ir", 32'(issue_ready), 32'd1);
        check("t5_rst_ovf", 32'(overflow), 32'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, (c % 2 == 0) ? 10'h3FF : 10'h000, 1'b0);
            check($sformatf("t5_no_push%0d", c), 32'(count), 32'd0);
            tick();
        end
        drive(1'b0, 10'h0, 1'b0);
        check("t5_final_vld", 32'(out_valid), 32'd0);

        // Ten push/pop pairs; pointers wrap twice around the four slots.
        for (int k = 1; k <= 10; k++) begin
            drive(1'b1, 10'h0, 1'b0);
            tick();
            drive(1'b0, 10'h0, 1'b0);
            tick();
            tick();
            drive(1'b0, 10'(k), 1'b0);
            tick();
            drive(1'b0, ~10'(k), 1'b1);
            check($sformatf("t6_cnt%0d", k), 32'(count), 32'd1);
            check($sformatf("t6_dat%0d", k), 32'(out_data), 32'(k));
            tick();
            drive(1'b0, 10'h0, 1'b0);
            check($sformatf("t6_empty%0d", k), 32'(count), 32'd0);
        end
        check("t6_ovf", 32'(overflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_result_fifo.md
Name: pipe_result_fifo

Overview:
Downstream companion to the Pipelining arithmetic stage. Pipelining carries no valid signal, so this block carries its own valid bit alongside each operand issue, delayed by the pipeline latency. It captures each aligned F result into a small FIFO and hands results to the consumer through a valid/ready interface. It also gives the operand source credit-based backpressure, so no result is ever dropped when the source obeys issue_ready.

Parameters:
N, 10, data width of F (matches Pipelining n)
LATENCY, 3, clock edges from operand sampling to F valid at f_in; legal range 1..8
DEPTH, 4, FIFO entries; power of two, at least 2

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  high in a cycle whose A/B/C/D are sampled by Pipelining at the next edge (an "issue")
issue_ready  output  1  source may issue this cycle; combinational
f_in  input  N  F output of Pipelining
out_data  output  N  FIFO head
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head this cycle
count  output  $clog2(DEPTH+1)  FIFO occupancy
overflow  output  1  sticky: an aligned result was dropped

Behaviour:
- Reset (async assert, sync release) clears vpipe, FIFO pointers, count and overflow. Reset values: out_valid=0, count=0, overflow=0, issue_ready=1. out_data is don't-care while out_valid=0.
- Valid alignment: vpipe is a LATENCY-bit shift register with vpipe[0] <= in_valid. An issue sampled at edge t makes f_in valid in the cycle after edge t+LATENCY-1. vpipe[LATENCY-1] is high in exactly that cycle.
- push = vpipe[LATENCY-1]. f_in is written at the edge ending that cycle, so it reaches the FIFO LATENCY+1 edges after the issue.
- pop = out_valid && out_ready. out_data is show-ahead: it shows the head combinationally from storage and stays stable while out_valid=1 and out_ready=0.
- Push and pop in the same edge:
  - both succeed and count is unchanged;
  - this holds when full (the popped slot is reused) and when the FIFO holds exactly one entry.
- Push while full with no pop: the data is dropped, pointers are unchanged and overflow is set to 1. overflow stays set until reset.
- Pop when empty: cannot occur (out_valid=0); out_ready is ignored.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is kept as an explicit register. full = (count==DEPTH), empty = (count==0).
- Credit: inflight = number of ones in vpipe. issue_ready = (count + inflight) < DEPTH.
  - The sum uses width $clog2(DEPTH+LATENCY+1), so it cannot wrap.
  - pop in the current cycle is not credited; this is conservative by one cycle.
- in_valid while issue_ready=0 is still tracked in vpipe (the block does not gate it). Overflow then results from the source violating the credit rule.
- Reset mid-operation: in-flight valid bits and stored results are discarded. Pipelining itself has no reset, so any stale F values are ignored because vpipe is clear.
- No combinational path from f_in to any output.

Decomposition:
- Shared package pipe_pkg:
  - N_DEFAULT=10 and LATENCY_DEFAULT=3;
  - a cnt_w(depth) width function;
  - a localparam for the credit-sum width.
- One natural sub-module: pipe_valid_delay (parameter LATENCY; ports clk, rst, d, q, inflight), holding vpipe and its popcount. The FIFO storage and control remain in pipe_result_fifo.

Test Plan:
- Reset, then one issue at edge 1 with f_in driven to 0x05A in the cycle after edge 3 (LATENCY=3): push at edge 4 -> out_valid=1, out_data=0x05A, count=1. out_ready=1 for one cycle -> count=0, out_valid=0.
- Back-to-back issues on 4 consecutive edges with f_in = 10,20,30,40 in the aligned cycles, out_ready=0:
  - after the 4th issue, issue_ready=0 while all 4 are in flight;
  - the FIFO fills to count=4, overflow=0;
  - draining yields 10,20,30,40 in order.
- FIFO full and out_ready=1 in the same cycle as an aligned result 55: count stays 4, head advances, 55 is last out, overflow=0.
- Ignore issue_ready and force a 5th issue while count=4, out_ready=0: the 5th result is dropped, overflow=1 and stays 1 after later drains; count=4.
- Fill 2 entries with 1 more in flight, then assert rst mid-cycle (asynchronously): outputs clear immediately (count=0, out_valid=0, issue_ready=1). No stray push occurs after release, even though f_in keeps toggling.
- Pointer wrap: 10 single-entry push/pop pairs with values 1..10 -> every value appears in order, count never exceeds 1, and pointers wrap twice.
